// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flappy_pkg
// Purpose  : Shared types for the flappy pipe/scroll datapath.
// Revision : 1.0
// ============================================================================
package flappy_pkg;

    localparam int ROWS = 16;

    typedef logic [ROWS-1:0] pipe_col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_scroller_scroll_div.sv
`default_nettype none
// ============================================================================
// Module   : scroll_div
// Purpose  : Divides the clock into one-cycle scroll tick pulses.
// Revision : 1.0
// ============================================================================
module scroll_div #(
    parameter int SCROLL_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                 c_CNT_W = $clog2(SCROLL_DIV);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SCROLL_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/pipe_scroller.sv
`default_nettype none
// ============================================================================
// Module   : pipe_scroller
// Purpose  : Buffers pipe columns, scrolls the playfield, detects collision
//            with the bird and keeps the score.
// Revision : 1.0
// ============================================================================
module pipe_scroller
    import flappy_pkg::*;
#(
    parameter int COLS       = 16,
    parameter int SCROLL_DIV = 4,
    parameter int GAP        = 4,
    parameter int BIRD_COL   = 3,
    parameter int SCORE_W    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     pipe_req,
    input  logic                     pipe_valid,
    input  logic [15:0]              pipe_col,
    input  logic [15:0]              bird_row,
    input  logic [$clog2(COLS)-1:0]  disp_col,
    output logic [15:0]              disp_row,
    output logic                     running,
    output logic                     game_over,
    output logic [SCORE_W-1:0]       score,
    output logic                     underrun
);

    localparam int                 c_SP_W      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_SP_W-1:0]  c_SP_LAST   = c_SP_W'(GAP - 1);
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

    state_t              r_state;
    state_t              w_state_next;
    pipe_col_t           r_col [COLS];
    logic [COLS-1:0]     r_flag;
    pipe_col_t           r_buf;
    logic                r_buf_full;
    logic [c_SP_W-1:0]   r_spacing;
    logic [SCORE_W-1:0]  r_score;
    logic                r_underrun;
    pipe_col_t           r_disp_row;

    logic w_run;
    logic w_enter_run;
    logic w_hit;
    logic w_tick;
    logic w_step;
    logic w_due;
    logic w_insert;
    logic w_xfer;

    assign w_run       = (r_state == RUN);
    assign w_enter_run = (r_state != RUN) && start;
    assign w_hit       = w_run && (((r_col[BIRD_COL] & bird_row) != '0) || (bird_row == '0));
    // A collision in a tick cycle wins: the field and score must freeze as hit.
    assign w_step      = w_tick && !w_hit;
    assign w_due       = (r_spacing == c_SP_LAST);
    assign w_insert    = w_step && w_due && r_buf_full;
    assign w_xfer      = pipe_req && pipe_valid;

    scroll_div #(
        .SCROLL_DIV (SCROLL_DIV)
    ) u_scroll_div (
        .clk    (clock),
        .rst    (reset),
        .i_en   (w_run),
        .i_clr  (w_enter_run),
        .o_tick (w_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_hit) w_state_next = OVER;
            OVER:    if (start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < COLS; i++) r_col[i] <= '0;
            r_flag <= '0;
        end else if (w_enter_run) begin
            for (int i = 0; i < COLS; i++) r_col[i] <= '0;
            r_flag <= '0;
        end else if (w_step) begin
            for (int i = 0; i < COLS - 1; i++) begin
                r_col[i]  <= r_col[i+1];
                r_flag[i] <= r_flag[i+1];
            end
            r_col[COLS-1]  <= w_insert ? r_buf : '0;
            r_flag[COLS-1] <= w_insert;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_spacing  <= '0;
            r_score    <= '0;
            r_underrun <= 1'b0;
        end else if (w_enter_run) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_spacing  <= c_SP_LAST;
            r_score    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_step && w_due && !r_buf_full;
            // Insert and transfer are exclusive: one needs a full buffer, the other an empty one.
            if (w_insert) r_buf_full <= 1'b0;
            if (w_xfer) begin
                r_buf      <= pipe_col;
                r_buf_full <= 1'b1;
            end
            if (w_step) begin
                if (!w_due) begin
                    r_spacing <= r_spacing + 1'b1;
                end else if (r_buf_full) begin
                    r_spacing <= '0;
                end
            end
            if (w_step && r_flag[BIRD_COL] && (r_score != c_SCORE_MAX)) begin
                r_score <= r_score + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_disp_row <= '0;
        end else begin
            r_disp_row <= (32'(disp_col) < COLS) ? r_col[disp_col] : '0;
        end
    end

    assign pipe_req  = w_run && !r_buf_full;
    assign running   = w_run;
    assign game_over = (r_state == OVER);
    assign score     = r_score;
    assign underrun  = r_underrun;
    assign disp_row  = r_disp_row;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_scroller
// Purpose  : Directed self-checking bench for pipe_scroller.
// Revision : 1.0
// ============================================================================
module tb_pipe_scroller;

    logic        clock;
    logic        reset;
    logic        start;
    logic        pipe_req;
    logic        pipe_valid;
    logic [15:0] pipe_col;
    logic [15:0] bird_row;
    logic [3:0]  disp_col;
    logic [15:0] disp_row;
    logic        running;
    logic        game_over;
    logic [7:0]  score;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_scroller #(
        .COLS       (16),
        .SCROLL_DIV (4),
        .GAP        (4),
        .BIRD_COL   (3),
        .SCORE_W    (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pipe_req   (pipe_req),
        .pipe_valid (pipe_valid),
        .pipe_col   (pipe_col),
        .bird_row   (bird_row),
        .disp_col   (disp_col),
        .disp_row   (disp_row),
        .running    (running),
        .game_over  (game_over),
        .score      (score),
        .underrun   (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        pipe_valid = 1'b0;
        pipe_col   = 16'h0000;
        bird_row   = 16'h0000;
        disp_col   = 4'd0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        check("rst_running",  32'(running),   32'd0);
        check("rst_gameover", 32'(game_over), 32'd0);
        check("rst_score",    32'(score),     32'd0);
        check("rst_pipe_req", 32'(pipe_req),  32'd0);
        check("rst_underrun", 32'(underrun),  32'd0);
        check("rst_disp_row", 32'(disp_row),  32'd0);

        // First game: generator always valid, bird in the gap
        pipe_col   = 16'hF81F;
        pipe_valid = 1'b1;
        bird_row   = 16'h0200;
        disp_col   = 4'd15;
        start      = 1'b1;
        cyc(1);
        start = 1'b0;
        check("run_entered",   32'(running),  32'd1);
        check("req_after_run", 32'(pipe_req), 32'd1);
        cyc(1);
        check("req_drop_xfer", 32'(pipe_req), 32'd0);
        cyc(3);
        check("req_after_tick1", 32'(pipe_req), 32'd1);
        cyc(1);
        check("tick1_col15", 32'(disp_row), 32'hF81F);

        // After 13 ticks: pipes at 3, 7, 11, 15
        cyc(47);
        check("t13_score",   32'(score),   32'd0);
        check("t13_running", 32'(running), 32'd1);
        disp_col = 4'd3;  cyc(1);
        check("t13_col3",  32'(disp_row), 32'hF81F);
        disp_col = 4'd7;  cyc(1);
        check("t13_col7",  32'(disp_row), 32'hF81F);
        disp_col = 4'd11; cyc(1);
        check("t13_col11", 32'(disp_row), 32'hF81F);
        disp_col = 4'd15; cyc(1);
        check("t13_col15", 32'(disp_row), 32'hF81F);
        check("t14_score", 32'(score),    32'd1);
        disp_col = 4'd13; cyc(1);
        check("t14_col13_empty", 32'(disp_row), 32'd0);
        cyc(15);
        check("t18_score",    32'(score),    32'd2);
        check("t18_running",  32'(running),  32'd1);
        check("no_underrun",  32'(underrun), 32'd0);

        // Bird moves to lit row 15; next pipe reaches col 3 at tick 21
        bird_row = 16'h8000;
        cyc(12);
        check("pre_hit_over", 32'(game_over), 32'd0);
        check("pre_hit_run",  32'(running),   32'd1);
        cyc(1);
        check("hit_over",     32'(game_over), 32'd1);
        check("hit_not_run",  32'(running),   32'd0);
        disp_col = 4'd3;
        cyc(4);
        check("over_score_frozen", 32'(score),    32'd2);
        check("over_field_frozen", 32'(disp_row), 32'hF81F);
        check("over_no_req",       32'(pipe_req), 32'd0);

        // Restart with the generator stalled
        pipe_valid = 1'b0;
        bird_row   = 16'h0200;
        start      = 1'b1;
        cyc(1);
        start = 1'b0;
        check("restart_run",   32'(running),   32'd1);
        check("restart_over",  32'(game_over), 32'd0);
        check("restart_score", 32'(score),     32'd0);
        check("restart_req",   32'(pipe_req),  32'd1);
        cyc(1);
        check("restart_field_clear", 32'(disp_row), 32'd0);
        disp_col = 4'd15;
        cyc(3);
        check("underrun_t1",      32'(underrun), 32'd1);
        cyc(1);
        check("underrun_t1_end",  32'(underrun), 32'd0);
        check("underrun_col15",   32'(disp_row), 32'd0);
        cyc(3);
        check("underrun_t2",      32'(underrun), 32'd1);
        pipe_valid = 1'b1;
        cyc(1);
        check("late_xfer_req",    32'(pipe_req), 32'd0);
        check("underrun_t2_end",  32'(underrun), 32'd0);
        cyc(3);
        check("t3_no_underrun",   32'(underrun), 32'd0);
        cyc(1);
        check("late_pipe_col15",  32'(disp_row), 32'hF81F);

        // Bird leaves the screen
        bird_row = 16'h0000;
        cyc(1);
        check("bird_gone_over", 32'(game_over), 32'd1);
        check("bird_gone_run",  32'(running),   32'd0);

        // Asynchronous reset in the middle of a game
        bird_row = 16'h0200;
        start    = 1'b1;
        cyc(1);
        start = 1'b0;
        check("game3_run", 32'(running), 32'd1);
        cyc(5);
        check("game3_col15", 32'(disp_row), 32'hF81F);
        reset = 1'b1;
        #1;
        check("async_rst_run", 32'(running),  32'd0);
        check("async_rst_req", 32'(pipe_req), 32'd0);
        check("async_rst_row", 32'(disp_row), 32'd0);
        cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            disp_col = 4'(i);
            cyc(1);
            check($sformatf("sweep_col%0d", i), 32'(disp_row), 32'd0);
        end
        check("post_rst_run",   32'(running),   32'd0);
        check("post_rst_over",  32'(game_over), 32'd0);
        check("post_rst_req",   32'(pipe_req),  32'd0);
        check("post_rst_score", 32'(score),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
